instrmem_loader: RTL and testbench
==================================

Name: instrmem_loader

Overview:
Boot loader that sits directly upstream of the pipelined RISC-I CPU's instruction-memory write port. It receives a program as a byte stream with a valid/ready handshake and assembles 32-bit instructions. It writes them through the CPU's InstrMEM write interface, verifies an XOR checksum, and then releases the CPU from reset. It holds the CPU in reset for the whole load and on any error.

Parameters:
ADDR_WIDTH, 10, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
RELEASE_DELAY, 2, cycles between checksum acceptance and release of o_CPU_RSTN (range 1..15).

Ports:
i_CLK  input  1  system clock, all logic on the rising edge.
i_RSTN  input  1  asynchronous active-low reset.
i_Start  input  1  begin a load; sampled only in IDLE, RUN and ERROR.
i_Byte  input  8  stream data byte.
i_Byte_Valid  input  1  i_Byte is valid.
o_Byte_Ready  output  1  loader can accept a byte.
o_InstrMEM_Write_Addr  output  ADDR_WIDTH  word address to the CPU instruction memory.
o_InstrMEM_Write_Instr  output  32  instruction word to write.
o_InstrMEM_MemWrite  output  1  one-cycle write strobe.
o_CPU_RSTN  output  1  active-low reset to the CPU (drives the CPU's i_RSTN).
o_Busy  output  1  load in progress.
o_Done  output  1  program loaded and CPU running.
o_Error  output  1  load failed; sticky until the next i_Start.

Behaviour:
- Reset (i_RSTN=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including o_CPU_RSTN=0 (CPU held in reset).
  - Address, byte counter, word counter and checksum registers clear.
  - Instruction-memory contents are untouched.
- Byte transfer: a byte is accepted on a rising edge where i_Byte_Valid & o_Byte_Ready. A valid byte while ready=0 is ignored, not queued.
- o_Byte_Ready=1 exactly in states LEN_LO, LEN_HI, DATA and CHECK, including cycles where a write strobe is being issued.
- States:
  - IDLE: i_Start=1 -> LEN_LO.
  - LEN_LO: accept low byte of word count N.
  - LEN_HI: accept high byte; N={hi,lo}.
    - If N==0 or N>2^ADDR_WIDTH -> ERROR.
    - Else clear checksum and word index, then -> DATA.
  - DATA: bytes are little-endian. The 1st byte goes to [7:0], the 2nd to [15:8], and so on.
    - Each accepted data byte is XORed into the 8-bit checksum.
    - When the 4th byte of a word is accepted, the next cycle drives o_InstrMEM_MemWrite=1 for exactly one cycle. In that cycle Addr = word index (0-based) and Instr = the assembled word.
    - The word index increments after the strobe.
    - Back-to-back bytes are allowed with no stall, so minimum spacing between strobes is 4 cycles.
    - When word N-1 is accepted -> CHECK. Its strobe still occurs in the following cycle.
  - CHECK: accept one byte.
    - Byte == checksum -> RELEASE.
    - Byte != checksum -> ERROR.
  - RELEASE: count RELEASE_DELAY cycles, then o_CPU_RSTN=1 and o_Done=1 (both registered, same edge) -> RUN.
  - RUN: o_CPU_RSTN=1 and o_Done=1 held. i_Start=1 -> o_CPU_RSTN=0 and o_Done=0 on the next edge -> LEN_LO (reload).
  - ERROR: o_Error=1, o_CPU_RSTN=0. i_Start=1 clears o_Error on the next edge -> LEN_LO.
- o_Busy=1 in LEN_LO, LEN_HI, DATA, CHECK and RELEASE. i_Start is ignored while o_Busy=1.
- o_InstrMEM_Write_Addr and o_InstrMEM_Write_Instr hold their last written values between strobes. o_InstrMEM_MemWrite is 0 except for single-cycle strobes.
- Word index never wraps. N=2^ADDR_WIDTH writes the last address 2^ADDR_WIDTH-1, then goes to CHECK.
- Asynchronous reset mid-load aborts immediately. Words already written stay in memory, and the next load starts from LEN_LO.

Test Plan:
1. Nominal load: Start, then bytes 02 00 78 56 34 12 EF BE AD DE 2A sent back-to-back. Required: strobe with addr 0 = 0x12345678, strobe with addr 1 = 0xDEADBEEF, exactly 2 strobes. o_CPU_RSTN and o_Done rise RELEASE_DELAY cycles after the 0x2A byte is accepted.
2. Same stream with checksum 0x2B: both writes still occur, o_Error=1, o_CPU_RSTN stays 0, o_Done=0. A following Start clears o_Error.
3. Length 00 00, and separately length 01 04 (1025, with ADDR_WIDTH=10): ERROR immediately after the length high byte is accepted, with no MemWrite strobe.
4. Stream from scenario 1 with i_Byte_Valid toggled 1/0/0/1 at random: identical writes and release as scenario 1. Bytes offered while ready=0 (IDLE, RELEASE) are not consumed.
5. Assert i_RSTN=0 after the 6th data byte: all outputs 0 asynchronously and addr 0 already written. Then rerun scenario 1 and check it completes normally.
6. From RUN, pulse i_Start: o_CPU_RSTN=0 next cycle. Load a 1-word program 01 00 13 00 00 00 13: addr 0 = 0x00000013 and the CPU is released again.

Source files
------------

// File: rtl/instrmem_loader.sv
// Boot loader feeding the RISC-I instruction-memory write port.
// Takes a byte stream: 16-bit word count (little-endian), then N little-endian 32-bit words,
// then one XOR checksum byte over the data bytes. The CPU is held in reset until the checksum
// is accepted and a short release delay has elapsed.
module instrmem_loader #(
   parameter int unsigned ADDR_WIDTH    = 10,
   parameter int unsigned RELEASE_DELAY = 2
) (
   input  logic                  i_CLK,
   input  logic                  i_RSTN,
   input  logic                  i_Start,
   input  logic [7:0]            i_Byte,
   input  logic                  i_Byte_Valid,
   output logic                  o_Byte_Ready,
   output logic [ADDR_WIDTH-1:0] o_InstrMEM_Write_Addr,
   output logic [31:0]           o_InstrMEM_Write_Instr,
   output logic                  o_InstrMEM_MemWrite,
   output logic                  o_CPU_RSTN,
   output logic                  o_Busy,
   output logic                  o_Done,
   output logic                  o_Error
);

   typedef enum logic [2:0] {
      StIdle,
      StLenLo,
      StLenHi,
      StData,
      StCheck,
      StRelease,
      StRun,
      StError
   } state_e;

   // Largest legal word count is the full memory, 2^ADDR_WIDTH.
   localparam logic [16:0] MaxWords = 17'(1) << ADDR_WIDTH;
   localparam logic [3:0]  RelDelay = 4'(RELEASE_DELAY);

   state_e                state_q, state_d;
   logic [7:0]            len_lo_q, len_lo_d;
   logic [ADDR_WIDTH-1:0] last_idx_q, last_idx_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [23:0]           word_q, word_d;
   logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
   logic [7:0]            csum_q, csum_d;
   logic [3:0]            delay_q, delay_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]           wr_instr_q, wr_instr_d;
   logic                  we_q, we_d;
   logic                  cpu_rstn_q, cpu_rstn_d;
   logic                  done_q, done_d;

   logic                  byte_ready;
   logic                  byte_acc;
   logic [16:0]           len_full;
   logic [16:0]           len_m1;

   // Handshake: the loader listens only while it expects length, data or checksum bytes.
   always_comb begin
      byte_ready = 1'b0;
      unique case (state_q)
         StLenLo, StLenHi, StData, StCheck: byte_ready = 1'b1;
         default:                           byte_ready = 1'b0;
      endcase
   end

   assign byte_acc = i_Byte_Valid & byte_ready;
   assign len_full = {1'b0, i_Byte, len_lo_q};
   assign len_m1   = len_full - 17'd1;

   // Next-state logic for the load sequence, write strobe and CPU release.
   always_comb begin
      state_d    = state_q;
      len_lo_d   = len_lo_q;
      last_idx_d = last_idx_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      word_idx_d = word_idx_q;
      csum_d     = csum_q;
      delay_d    = delay_q;
      wr_addr_d  = wr_addr_q;
      wr_instr_d = wr_instr_q;
      we_d       = 1'b0;
      cpu_rstn_d = cpu_rstn_q;
      done_d     = done_q;

      unique case (state_q)
         StIdle: begin
            if (i_Start) begin
               state_d = StLenLo;
            end
         end

         StLenLo: begin
            if (byte_acc) begin
               len_lo_d = i_Byte;
               state_d  = StLenHi;
            end
         end

         StLenHi: begin
            if (byte_acc) begin
               if ((len_full == 17'd0) || (len_full > MaxWords)) begin
                  state_d = StError;
               end else begin
                  // Store N-1 so the last-word test is a plain equality on the index.
                  last_idx_d = len_m1[ADDR_WIDTH-1:0];
                  csum_d     = 8'h00;
                  word_idx_d = '0;
                  byte_cnt_d = 2'd0;
                  state_d    = StData;
               end
            end
         end

         StData: begin
            if (byte_acc) begin
               csum_d     = csum_q ^ i_Byte;
               byte_cnt_d = byte_cnt_q + 2'd1;
               unique case (byte_cnt_q)
                  2'd0: word_d[7:0]   = i_Byte;
                  2'd1: word_d[15:8]  = i_Byte;
                  2'd2: word_d[23:16] = i_Byte;
                  default: begin
                     // Fourth byte completes the word; strobe it out next cycle.
                     we_d       = 1'b1;
                     wr_addr_d  = word_idx_q;
                     wr_instr_d = {i_Byte, word_q};
                     if (word_idx_q == last_idx_q) begin
                        // Index is left at the last word so a full-memory load never wraps.
                        state_d = StCheck;
                     end else begin
                        word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                     end
                  end
               endcase
            end
         end

         StCheck: begin
            if (byte_acc) begin
               if (i_Byte == csum_q) begin
                  delay_d = 4'd1;
                  state_d = StRelease;
               end else begin
                  state_d = StError;
               end
            end
         end

         StRelease: begin
            if (delay_q >= RelDelay) begin
               cpu_rstn_d = 1'b1;
               done_d     = 1'b1;
               state_d    = StRun;
            end else begin
               delay_d = delay_q + 4'd1;
            end
         end

         StRun: begin
            if (i_Start) begin
               cpu_rstn_d = 1'b0;
               done_d     = 1'b0;
               state_d    = StLenLo;
            end
         end

         StError: begin
            if (i_Start) begin
               state_d = StLenLo;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers; async reset leaves memory contents alone but drops everything here.
   always_ff @(posedge i_CLK or negedge i_RSTN) begin
      if (!i_RSTN) begin
         state_q    <= StIdle;
         len_lo_q   <= 8'h00;
         last_idx_q <= '0;
         byte_cnt_q <= 2'd0;
         word_q     <= 24'h000000;
         word_idx_q <= '0;
         csum_q     <= 8'h00;
         delay_q    <= 4'd0;
         wr_addr_q  <= '0;
         wr_instr_q <= 32'h00000000;
         we_q       <= 1'b0;
         cpu_rstn_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_lo_q   <= len_lo_d;
         last_idx_q <= last_idx_d;
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         word_idx_q <= word_idx_d;
         csum_q     <= csum_d;
         delay_q    <= delay_d;
         wr_addr_q  <= wr_addr_d;
         wr_instr_q <= wr_instr_d;
         we_q       <= we_d;
         cpu_rstn_q <= cpu_rstn_d;
         done_q     <= done_d;
      end
   end

   // Status flags decoded from the current state.
   always_comb begin
      o_Busy  = 1'b0;
      o_Error = 1'b0;
      unique case (state_q)
         StLenLo, StLenHi, StData, StCheck, StRelease: o_Busy = 1'b1;
         StError:                                      o_Error = 1'b1;
         default: begin
            o_Busy  = 1'b0;
            o_Error = 1'b0;
         end
      endcase
   end

   assign o_Byte_Ready           = byte_ready;
   assign o_InstrMEM_Write_Addr  = wr_addr_q;
   assign o_InstrMEM_Write_Instr = wr_instr_q;
   assign o_InstrMEM_MemWrite    = we_q;
   assign o_CPU_RSTN             = cpu_rstn_q;
   assign o_Done                 = done_q;

endmodule

// File: tb/tb_instrmem_loader.sv
// Bench for instrmem_loader: expected writes go into a scoreboard queue as streams are built,
// and a negedge monitor pops and compares them on every write strobe.
module tb_instrmem_loader;

   localparam int unsigned AW = 10;
   localparam int unsigned RD = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [7:0]    byte_in;
   logic          byte_valid;
   logic          byte_ready;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_instr;
   logic          mem_write;
   logic          cpu_rstn;
   logic          busy;
   logic          done;
   logic          error;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   instr;
   } wr_t;

   wr_t        exp_q[$];
   wr_t        mon_e;
   logic [7:0] stream_q[$];
   int         checks = 0;
   int         errors = 0;
   logic       we_prev = 1'b0;

   instrmem_loader #(
      .ADDR_WIDTH   (AW),
      .RELEASE_DELAY(RD)
   ) dut (
      .i_CLK                 (clk),
      .i_RSTN                (rst_n),
      .i_Start               (start),
      .i_Byte                (byte_in),
      .i_Byte_Valid          (byte_valid),
      .o_Byte_Ready          (byte_ready),
      .o_InstrMEM_Write_Addr (wr_addr),
      .o_InstrMEM_Write_Instr(wr_instr),
      .o_InstrMEM_MemWrite   (mem_write),
      .o_CPU_RSTN            (cpu_rstn),
      .o_Busy                (busy),
      .o_Done                (done),
      .o_Error               (error)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (mem_write === 1'b1) begin
         checks++;
         if (we_prev !== 1'b0) begin
            errors++;
            $display("FAIL strobe_width: strobe high %0d cycles, required 1", 2);
         end
         checks++;
         if (byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_during_strobe: got %b required 1", byte_ready);
         end
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %h instr %h, none required", wr_addr, wr_instr);
         end else begin
            mon_e = exp_q.pop_front();
            checks++;
            if (wr_addr !== mon_e.addr) begin
               errors++;
               $display("FAIL write_addr: got %h required %h", wr_addr, mon_e.addr);
            end
            checks++;
            if (wr_instr !== mon_e.instr) begin
               errors++;
               $display("FAIL write_instr: got %h required %h", wr_instr, mon_e.instr);
            end
         end
      end
      we_prev = mem_write;
   end

   task automatic do_reset();
      rst_n      = 1'b0;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer one byte from a negedge; returns at the negedge after it was accepted.
   task automatic send_byte(input logic [7:0] b, input bit rnd);
      int n = 0;
      if (rnd) begin
         byte_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      byte_in    = b;
      byte_valid = 1'b1;
      while (byte_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (byte_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL byte_timeout: ready %b after %0d cycles, required 1", byte_ready, n);
      end
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_stream(input bit rnd);
      foreach (stream_q[i]) send_byte(stream_q[i], rnd);
   endtask

   task automatic load_nominal_stream();
      stream_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
      exp_q.push_back({10'd0, 32'h12345678});
      exp_q.push_back({10'd1, 32'hDEADBEEF});
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      #1;
      checks++;
      if ({busy, byte_ready, mem_write, cpu_rstn, done, error} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b required 000000",
                  {busy, byte_ready, mem_write, cpu_rstn, done, error});
      end
      checks++;
      if ({wr_addr, wr_instr} !== '0) begin
         errors++;
         $display("FAIL reset_bus: got %h/%h required 0/0", wr_addr, wr_instr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_nominal();
      pulse_start();
      checks++;
      if ({busy, byte_ready, cpu_rstn} !== 3'b110) begin
         errors++;
         $display("FAIL nominal_started: busy/ready/rstn got %b required 110",
                  {busy, byte_ready, cpu_rstn});
      end
      load_nominal_stream();
      send_stream(1'b0);
      for (int i = 0; i < RD; i++) begin
         checks++;
         if ({cpu_rstn, done, busy} !== 3'b001) begin
            errors++;
            $display("FAIL nominal_hold: cycle %0d rstn/done/busy got %b required 001",
                     i, {cpu_rstn, done, busy});
         end
         @(negedge clk);
      end
      checks++;
      if ({cpu_rstn, done, busy, error} !== 4'b1100) begin
         errors++;
         $display("FAIL nominal_release: rstn/done/busy/err got %b required 1100",
                  {cpu_rstn, done, busy, error});
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL nominal_writes: %0d writes missing, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_bad_checksum();
      do_reset();
      pulse_start();
      load_nominal_stream();
      stream_q[10] = 8'h2B;
      send_stream(1'b0);
      repeat (RD + 2) @(negedge clk);
      checks++;
      if ({error, cpu_rstn, done, busy} !== 4'b1000) begin
         errors++;
         $display("FAIL badsum_state: err/rstn/done/busy got %b required 1000",
                  {error, cpu_rstn, done, busy});
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL badsum_writes: %0d writes missing, required 0", exp_q.size());
         exp_q.delete();
      end
      pulse_start();
      checks++;
      if ({error, busy} !== 2'b01) begin
         errors++;
         $display("FAIL badsum_clear: err/busy got %b required 01", {error, busy});
      end
   endtask

   task automatic test_bad_length();
      do_reset();
      pulse_start();
      stream_q = '{8'h00, 8'h00};
      send_stream(1'b0);
      checks++;
      if ({error, busy, byte_ready} !== 3'b100) begin
         errors++;
         $display("FAIL len_zero: err/busy/ready got %b required 100", {error, busy, byte_ready});
      end
      pulse_start();
      checks++;
      if (error !== 1'b0) begin
         errors++;
         $display("FAIL len_zero_clear: err got %b required 0", error);
      end
      stream_q = '{8'h01, 8'h04};
      send_stream(1'b0);
      checks++;
      if ({error, busy, cpu_rstn} !== 3'b100) begin
         errors++;
         $display("FAIL len_1025: err/busy/rstn got %b required 100", {error, busy, cpu_rstn});
      end
      repeat (3) @(negedge clk);
      checks++;
      if (error !== 1'b1) begin
         errors++;
         $display("FAIL len_sticky: err got %b required 1", error);
      end
   endtask

   task automatic test_gapped();
      do_reset();
      byte_in    = 8'h55;
      byte_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got %b required 0", byte_ready);
         end
         @(negedge clk);
      end
      byte_valid = 1'b0;
      pulse_start();
      load_nominal_stream();
      send_stream(1'b1);
      // Keep offering a junk byte through RELEASE; it must not be consumed.
      byte_in    = 8'hFF;
      byte_valid = 1'b1;
      for (int i = 0; i < RD; i++) begin
         checks++;
         if ({cpu_rstn, done, byte_ready} !== 3'b000) begin
            errors++;
            $display("FAIL gapped_hold: cycle %0d rstn/done/ready got %b required 000",
                     i, {cpu_rstn, done, byte_ready});
         end
         @(negedge clk);
      end
      checks++;
      if ({cpu_rstn, done, error} !== 3'b110) begin
         errors++;
         $display("FAIL gapped_release: rstn/done/err got %b required 110", {cpu_rstn, done, error});
      end
      repeat (2) @(negedge clk);
      byte_valid = 1'b0;
      checks++;
      if ({done, error, busy} !== 3'b100 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL gapped_final: done/err/busy got %b pending %0d required 100/0",
                  {done, error, busy}, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_abort();
      do_reset();
      pulse_start();
      load_nominal_stream();
      for (int i = 0; i < 8; i++) send_byte(stream_q[i], 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, byte_ready, mem_write, cpu_rstn, done, error} !== 6'b0 ||
          {wr_addr, wr_instr} !== '0) begin
         errors++;
         $display("FAIL abort_outputs: flags %b bus %h/%h required all 0",
                  {busy, byte_ready, mem_write, cpu_rstn, done, error}, wr_addr, wr_instr);
      end
      checks++;
      if (exp_q.size() != 1 || exp_q[0].addr !== 10'd1) begin
         errors++;
         $display("FAIL abort_addr0: pending %0d required 1 (addr 1 only)", exp_q.size());
      end
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_nominal();
   endtask

   task automatic test_reload();
      pulse_start();
      checks++;
      if ({cpu_rstn, done, busy} !== 3'b001) begin
         errors++;
         $display("FAIL reload_reset: rstn/done/busy got %b required 001", {cpu_rstn, done, busy});
      end
      stream_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
      exp_q.push_back({10'd0, 32'h00000013});
      send_stream(1'b0);
      repeat (RD) @(negedge clk);
      checks++;
      if ({cpu_rstn, done, error} !== 3'b110 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL reload_release: rstn/done/err got %b pending %0d required 110/0",
                  {cpu_rstn, done, error}, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_max_length();
      logic [7:0] csum = 8'h00;
      do_reset();
      pulse_start();
      stream_q = '{8'h00, 8'h04};
      for (int w = 0; w < (1 << AW); w++) begin
         logic [31:0] v = $urandom();
         for (int b = 0; b < 4; b++) begin
            stream_q.push_back(v[8*b +: 8]);
            csum ^= v[8*b +: 8];
         end
         exp_q.push_back({AW'(w), v});
      end
      stream_q.push_back(csum);
      send_stream(1'b0);
      repeat (RD) @(negedge clk);
      checks++;
      if ({cpu_rstn, done, error} !== 3'b110 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL max_len: rstn/done/err got %b pending %0d required 110/0",
                  {cpu_rstn, done, error}, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_reload();
      test_bad_checksum();
      test_bad_length();
      test_gapped();
      test_abort();
      test_max_length();
      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
